// File: rtl/seq_alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
package seq_alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between a source/sink (master) and the ALU (slave).
interface seq_alu_if #(parameter int WIDTH = 8);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             carry_out;
   logic             zero;
   logic             negative;
   logic             overflow;

   modport master (
      output in_valid, a, b, sel, out_ready,
      input  in_ready, out_valid, result, result_hi, carry_out, zero, negative, overflow
   );

   modport slave (
      input  in_valid, a, b, sel, out_ready,
      output in_ready, out_valid, result, result_hi, carry_out, zero, negative, overflow
   );

endinterface

// File: rtl/seq_alu_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per clock.
// done is high during the cycle whose edge performs the last step; product
// carries the post-step sum, so the caller captures it on that same edge.
module seq_alu_mul #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;
   logic               running;

   // Once the multiplier is exhausted mplier is zero, so product stays put.
   assign acc_next = acc + (mplier[0] ? mcand : '0);
   assign product  = acc_next;
   assign busy     = running;
   assign done     = running && (count == '0);

   // Load operands on start, then one shift-add step per cycle until terminal count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand   <= '0;
         acc     <= '0;
         mplier  <= '0;
         count   <= '0;
         running <= 1'b0;
      end else if (start) begin
         mcand   <= {{WIDTH{1'b0}}, a};
         acc     <= '0;
         mplier  <= b;
         count   <= CW'(WIDTH - 1);
         running <= 1'b1;
      end else if (running) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (count == '0) begin
            running <= 1'b0;
         end else begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and an iterative multiply.
//
// state  | meaning
// IDLE   | waiting for an operation; in_ready high
// EXEC   | multiply in progress; inputs ignored
// DONE   | result and flags valid, held until out_ready
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic      clk,
   input logic      rst,
   seq_alu_if.slave bus
);

   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   state_t             state;
   logic [WIDTH-1:0]   result;
   logic [WIDTH-1:0]   result_hi;
   logic               carry_out;
   logic               zero;
   logic               negative;
   logic               overflow;

   logic [WIDTH:0]     sum_ext;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry;
   logic               alu_ovf;

   logic               mul_start;
   logic               mul_busy;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.result    = result;
   assign bus.result_hi = result_hi;
   assign bus.carry_out = carry_out;
   assign bus.zero      = zero;
   assign bus.negative  = negative;
   assign bus.overflow  = overflow;

   assign mul_start = (state == S_IDLE) && bus.in_valid && (bus.sel == OP_MUL);

   seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (bus.a),
      .b       (bus.b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Single-cycle datapath for every opcode except MUL; MUL and reserved yield zero here.
   always_comb begin
      sum_ext   = '0;
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (bus.sel)
         OP_ADD: begin
            sum_ext   = {1'b0, bus.a} + {1'b0, bus.b};
            alu_res   = sum_ext[WIDTH-1:0];
            alu_carry = sum_ext[WIDTH];
            alu_ovf   = (bus.a[MSB] == bus.b[MSB]) && (alu_res[MSB] != bus.a[MSB]);
         end
         OP_SUB: begin
            sum_ext   = {1'b0, bus.a} - {1'b0, bus.b};
            alu_res   = sum_ext[WIDTH-1:0];
            alu_carry = sum_ext[WIDTH];
            alu_ovf   = (bus.a[MSB] != bus.b[MSB]) && (alu_res[MSB] != bus.a[MSB]);
         end
         OP_AND:  alu_res = bus.a & bus.b;
         OP_OR:   alu_res = bus.a | bus.b;
         OP_XOR:  alu_res = bus.a ^ bus.b;
         OP_SHL:  alu_res = bus.a << bus.b[SHW-1:0];
         default: alu_res = '0;
      endcase
   end

   // Control FSM; result and flags only update on edges that enter DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         result    <= '0;
         result_hi <= '0;
         carry_out <= 1'b0;
         zero      <= 1'b1;
         negative  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  if (bus.sel == OP_MUL) begin
                     state <= S_EXEC;
                  end else begin
                     result    <= alu_res;
                     result_hi <= '0;
                     carry_out <= alu_carry;
                     zero      <= (alu_res == '0);
                     negative  <= alu_res[MSB];
                     overflow  <= alu_ovf;
                     state     <= S_DONE;
                  end
               end
            end
            S_EXEC: begin
               if (mul_done) begin
                  result    <= mul_product[WIDTH-1:0];
                  result_hi <= mul_product[2*WIDTH-1:WIDTH];
                  carry_out <= 1'b0;
                  zero      <= (mul_product == '0);
                  negative  <= mul_product[2*WIDTH-1];
                  overflow  <= 1'b0;
                  state     <= S_DONE;
               end else if (!mul_busy) begin
                  // multiplier lost its operation; abandon rather than wait forever
                  state <= S_IDLE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
